// File: rtl/encode_32to5_seq.sv
// Sequential 32-to-5 request encoder: captures request pulses into a pending set and issues
// one index per cycle through a ready/valid slot. Define ENCODE_ROUND_ROBIN_EN for round-robin.
module encode_32to5_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] x,
    input  logic        y_ready,
    output logic        y_valid,
    output logic [4:0]  y,
    output logic [31:0] pending,
    output logic        ovf
);

    logic [31:0] r_pending;
    logic        r_y_valid;
    logic [4:0]  r_y;
    logic        r_ovf;

    logic        w_slot_free;
    logic        w_issue;
    logic [4:0]  w_sel;
    logic [31:0] w_issue_mask;
    logic [31:0] w_pend_after;
    logic        w_drop;

`ifdef ENCODE_ROUND_ROBIN_EN
    logic [4:0] r_rr_ptr;

    // Search starts one past the last issued index and wraps; lowest offset wins.
    function automatic logic [4:0] rr_pick(input logic [31:0] req, input logic [4:0] ptr);
        logic [4:0] idx;
        rr_pick = '0;
        for (int i = 31; i >= 0; i--) begin
            idx = ptr + 5'(i) + 5'd1;
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign w_sel = rr_pick(r_pending, r_rr_ptr);
`else
    function automatic logic [4:0] low_pick(input logic [31:0] req);
        low_pick = '0;
        for (int i = 31; i >= 0; i--) begin
            if (req[i]) low_pick = 5'(i);
        end
    endfunction

    assign w_sel = low_pick(r_pending);
`endif

    assign w_slot_free  = !r_y_valid || y_ready;
    assign w_issue      = w_slot_free && (r_pending != '0);
    assign w_issue_mask = w_issue ? (32'd1 << w_sel) : 32'd0;
    assign w_pend_after = r_pending & ~w_issue_mask;
    // A bit being issued this edge is free to accept a new event.
    assign w_drop       = en && ((x & w_pend_after) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_y_valid <= 1'b0;
            r_y       <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pending <= en ? (w_pend_after | x) : w_pend_after;
            r_ovf     <= r_ovf | w_drop;
            if (w_slot_free) begin
                r_y_valid <= w_issue;
                if (w_issue) r_y <= w_sel;
            end
        end
    end

`ifdef ENCODE_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 5'd31;
        end else if (w_issue) begin
            r_rr_ptr <= w_sel;
        end
    end
`endif

    assign pending = r_pending;
    assign y_valid = r_y_valid;
    assign y       = r_y;
    assign ovf     = r_ovf;

endmodule
